// File: rtl/relu_writeback_if.sv
// Upstream row stream and output-buffer write port of relu_writeback.
// The slave modport is the block's view; master is the surrounding system's view.
interface relu_writeback_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [63:0]       in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              wr_ready;

    modport master (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/relu_writeback.sv
// Applies per-lane int8 ReLU to bias-sum rows and writes them to consecutive
// output-buffer addresses through a small FIFO that absorbs write backpressure.
module relu_writeback #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    relu_writeback_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rows_q;
    logic              relu_q;
    logic [ADDR_W-1:0] acc_cnt;
    logic [ADDR_W-1:0] wr_cnt;

    logic [63:0]       mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              active;
    logic [63:0]       relu_row;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign active = (state == RUN) || (state == DRAIN);

    assign bus.in_ready = rst_n && (state == RUN) && !full && (acc_cnt < rows_q);
    assign bus.wr_en    = rst_n && active && !empty;
    assign bus.wr_data  = bus.wr_en ? mem[rd_ptr[PTR_W-1:0]] : '0;
    assign bus.wr_addr  = rst_n ? (base_q + wr_cnt) : '0;
    assign busy         = rst_n && (state != IDLE);
    assign done         = rst_n && (state == DONE);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.wr_en && bus.wr_ready;

    always_comb begin
        relu_row = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            relu_row[8*k +: 8] = (relu_q && bus.in_data[8*k + 7]) ? 8'h00 : bus.in_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= relu_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            relu_q  <= 1'b0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        rows_q  <= num_rows;
                        relu_q  <= relu_en;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        state   <= (num_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (acc_cnt == rows_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_cnt == rows_q) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // push/pop only occur in RUN/DRAIN, so they never collide with the IDLE clears
            if (push) begin
                acc_cnt <= acc_cnt + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule
